// File: rtl/ppct_mult_arbiter_if.sv
// Request/response bus between the requesting PEs and the shared PPCT
// multiplier. Defining PPCT_EXACT_MODE_EN adds the per-requester req_exact
// lines, which travel with the operands.
interface ppct_mult_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ*WIDTH-1:0] req_y;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [2*WIDTH-1:0]    rsp_data;
   logic [IDW-1:0]        rsp_id;
`ifdef PPCT_EXACT_MODE_EN
   logic [NREQ-1:0]       req_exact;

   modport master (
      output req_valid, req_x, req_y, req_exact, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_x, req_y, req_exact, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
`else
   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
`endif
endinterface

// File: rtl/ppct_mult_arbiter.sv
// Round-robin arbiter in front of a shared column-truncated (PPCT)
// approximate multiplier. Two pipeline stages: operand register, then
// product register; responses carry the originating requester id.
// Optional feature: PPCT_EXACT_MODE_EN adds a per-op exact-multiply flag.
module ppct_mult_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned THETA = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   ppct_mult_arbiter_if.slave   bus,
   output logic [15:0]          ops_cnt
);
   localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned ID1W = IDW + 1;
   localparam int unsigned PW   = 2 * WIDTH;

   typedef logic [IDW-1:0] id_t;

   // Truncated partial-product sum: low t_i bits of x are dropped in row i.
   function automatic logic [PW-1:0] ppct_mul(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             exact);
      logic [PW-1:0]    acc;
      logic [WIDTH-1:0] row;
      int unsigned      t;
      acc = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         t   = (!exact && (i < THETA)) ? (THETA - i) : 32'd0;
         row = ((x >> t) << t) & {WIDTH{y[i]}};
         acc = acc + ({{WIDTH{1'b0}}, row} << i);
      end
      return acc;
   endfunction

   logic             s1_v;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   id_t              s1_id;
   logic             s2_v;
   logic [PW-1:0]    s2_data;
   id_t              s2_id;
   id_t              rr_ptr;

   logic             s2_hold;
   logic             s1_adv;
   logic             s1_free;
   logic             gnt_any;
   id_t              gnt_idx;
   logic [IDW:0]     scan_sum;
   logic [NREQ-1:0]  ready;
   logic             xfer;
   logic [WIDTH-1:0] sel_x;
   logic [WIDTH-1:0] sel_y;
   logic [PW-1:0]    prod;
`ifdef PPCT_EXACT_MODE_EN
   logic             sel_exact;
   logic             s1_exact;
`endif

   assign s2_hold = s2_v & ~bus.rsp_ready;
   assign s1_adv  = ~s2_hold;
   assign s1_free = ~s1_v | s1_adv;

   // Round-robin scan: first valid requester at or above rr_ptr, with wrap.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_sum = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         scan_sum = {1'b0, rr_ptr} + ID1W'(off);
         if (scan_sum >= ID1W'(NREQ)) scan_sum = scan_sum - ID1W'(NREQ);
         if (!gnt_any && bus.req_valid[scan_sum[IDW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_sum[IDW-1:0];
         end
      end
   end

   // Grant only when stage 1 can take an operand; nothing granted in reset.
   always_comb begin
      ready = '0;
      xfer  = 1'b0;
      if (!rst && s1_free && gnt_any) begin
         ready[gnt_idx] = 1'b1;
         xfer           = 1'b1;
      end
   end

   assign bus.req_ready = ready;

   // Operand mux for the granted requester.
   always_comb begin
      sel_x = '0;
      sel_y = '0;
`ifdef PPCT_EXACT_MODE_EN
      sel_exact = 1'b0;
`endif
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_x = bus.req_x[i*WIDTH +: WIDTH];
            sel_y = bus.req_y[i*WIDTH +: WIDTH];
`ifdef PPCT_EXACT_MODE_EN
            sel_exact = bus.req_exact[i];
`endif
         end
      end
   end

   // Multiplier between the operand and product registers.
   always_comb begin
`ifdef PPCT_EXACT_MODE_EN
      prod = ppct_mul(s1_x, s1_y, s1_exact);
`else
      prod = ppct_mul(s1_x, s1_y, 1'b0);
`endif
   end

   // Round-robin pointer moves past the winner only on a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Stage 1: operand register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v  <= 1'b0;
         s1_x  <= '0;
         s1_y  <= '0;
         s1_id <= '0;
`ifdef PPCT_EXACT_MODE_EN
         s1_exact <= 1'b0;
`endif
      end else if (xfer) begin
         s1_v  <= 1'b1;
         s1_x  <= sel_x;
         s1_y  <= sel_y;
         s1_id <= gnt_idx;
`ifdef PPCT_EXACT_MODE_EN
         s1_exact <= sel_exact;
`endif
      end else if (s1_adv) begin
         s1_v <= 1'b0;
      end
   end

   // Stage 2: product register, frozen while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v    <= 1'b0;
         s2_data <= '0;
         s2_id   <= '0;
      end else if (s1_adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_data <= prod;
            s2_id   <= s1_id;
         end
      end
   end

   // Completed-response counter, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_cnt <= '0;
      end else if (s2_v && bus.rsp_ready && (ops_cnt != 16'hFFFF)) begin
         ops_cnt <= ops_cnt + 16'd1;
      end
   end

   assign bus.rsp_valid = s2_v;
   assign bus.rsp_data  = s2_data;
   assign bus.rsp_id    = s2_id;
endmodule

// File: tb/tb_ppct_mult_arbiter.sv
// Scoreboard bench for ppct_mult_arbiter (NREQ=4, WIDTH=8, THETA=6).
module tb_ppct_mult_arbiter;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned THETA = 6;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ops_cnt;

   ppct_mult_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   ppct_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .THETA(THETA)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .ops_cnt (ops_cnt)
   );

   always #5 clk = ~clk;

   // Fixed operands per requester with hand-computed products.
   logic [7:0]  op_x       [4] = '{8'hFF, 8'h80, 8'hFF, 8'hF0};
   logic [7:0]  op_y       [4] = '{8'h01, 8'h80, 8'hFF, 8'h03};
   logic [15:0] prod_trunc [4] = '{16'h00C0, 16'h4000, 16'hFCC0, 16'h0280};
   logic [15:0] prod_exact [4] = '{16'h00FF, 16'h4000, 16'hFE01, 16'h02D0};

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];

   int          m_rr;
   logic        m_s1_v;
   logic        m_s2_v;
   logic [15:0] m_ops;
   logic        prev_hold;
   logic [15:0] prev_data;
   logic [1:0]  prev_id;
   int          stall_xfers = 0;
   logic        in_stall = 1'b0;

   int          g;
   int          idx;
   logic [3:0]  exp_rdy;
   logic        hold;
   logic        free;
   exp_t        e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Asserted mid-cycle; outputs must clear without waiting for a clock.
   task automatic pulse_reset();
      #1 rst = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_ops_cnt", 32'(ops_cnt), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: checks handshakes at the falling edge, predicts grants and
   // pushes expected responses, pops and compares delivered responses.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
         chk("rst_rsp_valid_mon", 32'(bus.rsp_valid), 32'd0);
         chk("rst_ops_cnt_mon", 32'(ops_cnt), 32'd0);
         m_rr      = 0;
         m_s1_v    = 1'b0;
         m_s2_v    = 1'b0;
         m_ops     = '0;
         prev_hold = 1'b0;
         sb.delete();
      end else begin
         if (prev_hold) begin
            chk("hold_rsp_data", 32'(bus.rsp_data), 32'(prev_data));
            chk("hold_rsp_id", 32'(bus.rsp_id), 32'(prev_id));
         end
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_s2_v));
         chk("ops_cnt", 32'(ops_cnt), 32'(m_ops));

         hold    = m_s2_v & ~bus.rsp_ready;
         free    = ~m_s1_v | ~hold;
         exp_rdy = '0;
         g       = -1;
         if (free) begin
            for (int off = 0; off < 4; off++) begin
               idx = (m_rr + off) % 4;
               if (g < 0 && bus.req_valid[idx]) begin
                  g            = idx;
                  exp_rdy[idx] = 1'b1;
               end
            end
         end
         chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));

         if (bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got id %0d data %0h expected no response at %0t",
                        bus.rsp_id, bus.rsp_data, $time);
            end else begin
               e = sb.pop_front();
               chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
               chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            end
            if (m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
         end

         if (g >= 0) begin
            e.id = 2'(g);
`ifdef PPCT_EXACT_MODE_EN
            e.data = bus.req_exact[g] ? prod_exact[g] : prod_trunc[g];
`else
            e.data = prod_trunc[g];
`endif
            sb.push_back(e);
            m_rr = (g + 1) % 4;
            if (in_stall) stall_xfers++;
         end
         if (!hold) m_s2_v = m_s1_v;
         if (g >= 0) m_s1_v = 1'b1;
         else if (!hold) m_s1_v = 1'b0;

         prev_hold = bus.rsp_valid & ~bus.rsp_ready;
         prev_data = bus.rsp_data;
         prev_id   = bus.rsp_id;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish by 1000000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      bus.req_x     = {op_x[3], op_x[2], op_x[1], op_x[0]};
      bus.req_y     = {op_y[3], op_y[2], op_y[1], op_y[0]};
`ifdef PPCT_EXACT_MODE_EN
      bus.req_exact = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("reset_ops_cnt", 32'(ops_cnt), 32'd0);
      rst = 1'b0;

      // Single op from requester 0, then requester 2.
      cyc();
      bus.req_valid = 4'b0001;
      cyc();
      bus.req_valid = '0;
      repeat (4) cyc();
      bus.req_valid = 4'b0100;
      cyc();
      bus.req_valid = '0;
      repeat (4) cyc();
`ifdef PPCT_EXACT_MODE_EN
      bus.req_exact = 4'b0100;
      bus.req_valid = 4'b0100;
      cyc();
      bus.req_valid = '0;
      bus.req_exact = '0;
      repeat (4) cyc();
`endif

      // All requesters valid from reset: grants rotate 0,1,2,3,...
      pulse_reset();
      bus.req_valid = 4'b1111;
      repeat (8) cyc();
      bus.req_valid = '0;
      repeat (4) cyc();

      // Consumer stall on an empty pipeline: exactly two ops get in.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      in_stall      = 1'b1;
      repeat (5) cyc();
      in_stall = 1'b0;
      chk("stall_accepts", 32'(stall_xfers), 32'd2);
      bus.rsp_ready = 1'b1;
      cyc();
      bus.req_valid = '0;
      repeat (6) cyc();
      chk("drain_empty", 32'(sb.size()), 32'd0);

      // Reset with both stages full; first grant afterwards goes to 0.
      bus.req_valid = 4'b1111;
      repeat (3) cyc();
      pulse_reset();
      @(negedge clk);
      #1;
      chk("first_grant_after_rst", 32'(bus.req_ready), 32'd1);

      // Long run to saturate the response counter.
      repeat (65545) cyc();
      chk("ops_cnt_sat", 32'(ops_cnt), 32'hFFFF);
      repeat (5) cyc();
      chk("ops_cnt_sat_hold", 32'(ops_cnt), 32'hFFFF);
      bus.req_valid = '0;
      repeat (4) cyc();
      chk("final_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
